// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared FSM state type and requester indices for memory_arbiter.
package memory_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr: two-input arbitration core, pointer names the requester preferred on conflict.
module memory_arbiter_rr
  import memory_arbiter_pkg::*;
(
  input  logic       en,
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[REQ0] = en && req[REQ0] && (!req[REQ1] || ptr == REQ0);
    gnt[REQ1] = en && req[REQ1] && (!req[REQ0] || ptr == REQ1);
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-requester arbiter and clear sequencer in front of a single-port RAM.
// Define MEMORY_ARBITER_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic                     mem_write,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);
  state_t state;
  logic [ADDRESS_WIDTH-1:0] cnt, addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0] gnt;
  logic ptr;
`ifdef MEMORY_ARBITER_RR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= REQ0;
    else ptr <= gnt[REQ0] ? REQ1 : gnt[REQ1] ? REQ0 : ptr;
`else
  assign ptr = REQ0;
`endif
  memory_arbiter_rr u_rr (
    .en (state == ST_IDLE && !clr_start),
    .req({req1, req0}),
    .ptr(ptr),
    .gnt(gnt)
  );
  assign gnt0 = gnt[REQ0];
  assign gnt1 = gnt[REQ1];
  assign clr_busy = state == ST_CLEAR;
  assign rdata = mem_data_out;
  assign mem_write = clr_busy || (gnt0 && we0) || (gnt1 && we1);
  // Idle cycles replay the last driven address/data so the RAM bus stays quiet.
  assign mem_addr = clr_busy ? cnt : gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
  assign mem_data_in = clr_busy ? CLEAR_VALUE : gnt0 ? wdata0 : gnt1 ? wdata1 : data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      addr_q  <= mem_addr;
      data_q  <= mem_data_in;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (state == ST_IDLE) begin
        cnt <= '0;
        if (clr_start) state <= ST_CLEAR;
      end else begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector table plus clear-sweep and mid-sweep reset sequences.
module tb_memory_arbiter;
`ifdef MEMORY_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, clr_start = 0;
  logic [3:0] addr0 = 0, addr1 = 0, mem_addr;
  logic [7:0] wdata0 = 0, wdata1 = 0, rdata, mem_data_in, mem_data_out;
  logic gnt0, gnt1, rvalid0, rvalid1, clr_busy, mem_write;
  logic [7:0] ram [16];
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .CLEAR_VALUE(8'h3C)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  // Behavioural single-port RAM, read-first with one cycle of output latency.
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_data_in;
    mem_data_out <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; clr_start = 0;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); req0 = 1; we0 = 1; addr0 = a; wdata0 = d;
    #1 chk("wr_gnt0", gnt0, 1);
  endtask

  task automatic rd0(input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk); req0 = 1; we0 = 0; addr0 = a;
    #1 chk("rd_gnt0", gnt0, 1);
    @(negedge clk); idle_inputs();
    #1 chk("rd_rvalid0", rvalid0, 1);
    chk("rd_data", rdata, exp);
  endtask

  typedef struct {
    logic r0, w0; logic [3:0] a0; logic [7:0] d0;
    logic r1, w1; logic [3:0] a1; logic [7:0] d1;
    logic g0, g1, mw; logic [3:0] ma; logic [7:0] md;
    logic v0, v1; logic [7:0] rd; logic crd;
  } vec_t;
  vec_t v [10];

  initial begin
    v[0] = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0, 8'h00, 0};
    v[1] = '{1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00, 1, 0, 1, 4'd3, 8'hA5, 0, 0, 8'h00, 0};
    v[2] = '{1, 0, 4'd3, 8'h11, 0, 0, 4'd0, 8'h00, 1, 0, 0, 4'd3, 8'h11, 0, 0, 8'h00, 0};
    v[3] = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd3, 8'h11, 1, 0, 8'hA5, 1};
    v[4] = '{0, 0, 4'd0, 8'h00, 1, 1, 4'd7, 8'h5A, 0, 1, 1, 4'd7, 8'h5A, 0, 0, 8'h00, 0};
    v[5] = '{1, 0, 4'd7, 8'h00, 1, 0, 4'd3, 8'h00, 1, 0, 0, 4'd7, 8'h00, 0, 0, 8'h00, 0};
    v[6] = '{1, 0, 4'd7, 8'h00, 1, 0, 4'd3, 8'h00, !RR, RR, 0, RR ? 4'd3 : 4'd7, 8'h00, 1, 0, 8'h5A, 1};
    v[7] = '{1, 0, 4'd7, 8'h00, 1, 0, 4'd3, 8'h00, 1, 0, 0, 4'd7, 8'h00, !RR, RR, RR ? 8'hA5 : 8'h5A, 1};
    v[8] = '{1, 0, 4'd7, 8'h00, 1, 0, 4'd3, 8'h00, !RR, RR, 0, RR ? 4'd3 : 4'd7, 8'h00, 1, 0, 8'h5A, 1};
    v[9] = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 0, RR ? 4'd3 : 4'd7, 8'h00, !RR, RR, RR ? 8'hA5 : 8'h5A, 1};

    repeat (2) @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_mem", {mem_write, mem_addr, mem_data_in}, 0);
    rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0 = v[i].r0; we0 = v[i].w0; addr0 = v[i].a0; wdata0 = v[i].d0;
      req1 = v[i].r1; we1 = v[i].w1; addr1 = v[i].a1; wdata1 = v[i].d1;
      #1;
      chk($sformatf("v%0d_gnt", i), {gnt0, gnt1}, {v[i].g0, v[i].g1});
      chk($sformatf("v%0d_mem", i), {mem_write, mem_addr, mem_data_in}, {v[i].mw, v[i].ma, v[i].md});
      chk($sformatf("v%0d_rvalid", i), {rvalid0, rvalid1}, {v[i].v0, v[i].v1});
      if (v[i].crd) chk($sformatf("v%0d_rdata", i), rdata, v[i].rd);
    end

    // Clear sweep launched while requester 1 waits with a read.
    @(negedge clk); req1 = 1; we1 = 0; addr1 = 4'd5; clr_start = 1;
    #1 chk("clr_start_gnt", {gnt0, gnt1}, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); clr_start = 0;
      #1;
      chk($sformatf("clr%0d_busy", i), {clr_busy, gnt1}, 2'b10);
      chk($sformatf("clr%0d_mem", i), {mem_write, mem_addr, mem_data_in}, {1'b1, 4'(i), 8'h3C});
    end
    @(negedge clk);
    #1 chk("clr_done", {clr_busy, gnt1}, 2'b01);
    @(negedge clk); idle_inputs();
    #1 chk("clr_rvalid1", rvalid1, 1);
    chk("clr_rdata1", rdata, 8'h3C);
    rd0(4'd3, 8'h3C);
    rd0(4'd15, 8'h3C);

    // Reset in the middle of a sweep leaves addresses 0..4 cleared only.
    for (int a = 0; a < 7; a++) wr0(4'(a), 8'h77);
    @(negedge clk); idle_inputs(); clr_start = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); clr_start = 0;
    end
    @(negedge clk);
    #1 chk("mid_addr5", {clr_busy, mem_addr}, {1'b1, 4'd5});
    rst_n = 0;
    #1 chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_mem", {mem_write, mem_addr, mem_data_in}, 0);
    @(negedge clk); rst_n = 1;
    for (int a = 0; a < 7; a++) rd0(4'(a), a < 5 ? 8'h3C : 8'h77);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter and sequencer in front of the single-port synchronous block RAM. It shares the RAM's one address/data/write port between requester 0 and requester 1, and returns read data one cycle after each accepted access. It also runs an on-demand clear sweep that writes a fixed value to every address. It sits directly between the RAM and the two client blocks; all RAM accesses in the design go through it.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDRESS_WIDTH, 10, RAM address width; depth is 2**ADDRESS_WIDTH
- CLEAR_VALUE, 0, word written to every address by the clear sweep

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request; held high until the matching gnt
- we0, we1  in  1  write (1) / read (0) for that request
- addr0, addr1  in  ADDRESS_WIDTH  access address
- wdata0, wdata1  in  DATA_WIDTH  write data
- gnt0, gnt1  out  1  access accepted this cycle (combinational)
- rvalid0, rvalid1  out  1  read data valid, one cycle after a read grant
- rdata  out  DATA_WIDTH  shared read data; equals mem_data_out
- clr_start  in  1  single-cycle pulse that starts the clear sweep
- clr_busy  out  1  clear sweep in progress
- mem_addr  out  ADDRESS_WIDTH  to RAM addr
- mem_data_in  out  DATA_WIDTH  to RAM data_in
- mem_write  out  1  to RAM write
- mem_data_out  in  DATA_WIDTH  from RAM data_out (registered in the RAM, 1-cycle latency)

## Operation
- FSM states: IDLE and CLEAR. Reset state is IDLE.
- IDLE, then CLEAR: on clr_start=1. In that cycle no grant is issued, even if requests are present.
- CLEAR, then IDLE: after the write to the last address, 2**ADDRESS_WIDTH-1.
- IDLE arbitration:
  - At most one gnt per cycle.
  - If only one req is high, that requester is granted.
  - If both are high, the winner is chosen by the policy in Configuration.
  - The mem_* outputs are driven combinationally from the granted requester.
  - When nothing is granted, mem_write=0 and mem_addr/mem_data_in hold their last driven values.
- Read grant: a 1-cycle pipeline flag asserts rvalidN in the next cycle.
- Write grant: no rvalid is produced.
- CLEAR operation:
  - A clear counter starts at 0 and increments by 1 each cycle.
  - Each cycle drives mem_write=1, mem_addr=counter, mem_data_in=CLEAR_VALUE.
  - gnt0 and gnt1 are held at 0; requesters stall with req held.
  - clr_start is ignored while in CLEAR.
- Read-during-write: RAM semantics apply. A read issued in the cycle after a write to the same address returns the new data. There is no forwarding inside this block.
- Reset mid-sweep: the FSM returns to IDLE and the counter clears to 0. The RAM contents are left partially cleared; this is not an error.

## Timing
- Reset values:
  - gnt0 = gnt1 = 0
  - rvalid0 = rvalid1 = 0
  - clr_busy = 0
  - mem_write = 0, mem_addr = 0, mem_data_in = 0
  - round-robin pointer = requester 0 preferred
- Read latency: grant at edge N; rvalidN and rdata are valid in the cycle after edge N+1.
- Throughput: one access per cycle, with back-to-back grants allowed. Both rvalid signals are never high in the same cycle.
- Clear duration: clr_busy rises the cycle after clr_start and stays high for exactly 2**ADDRESS_WIDTH cycles. The first grant is possible in the cycle clr_busy falls.
- An rvalid from a read granted just before clr_start still appears on schedule.

## Configuration
- Macro: MEMORY_ARBITER_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - After a grant, the pointer moves to the requester that was not granted.
- Undefined: fixed priority; requester 0 always wins a conflict. The pointer register is not instantiated.

## Structure
- Shared package memory_arbiter_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR)
  - the requester index constants (REQ0 = 0, REQ1 = 1)
- One sub-module, memory_arbiter_rr: the two-input arbitration core (requests plus pointer in, one-hot grant out).
- The FSM, clear counter and rvalid pipeline stay in the top module.

## Test plan
- Reset release, idle: rst_n 0 to 1 with no req. All outputs stay at reset values and mem_write=0.
- Single requester:
  - req0 writes 0xA5 to addr 3; gnt0=1 the same cycle.
  - req0 then reads addr 3; rvalid0=1 one cycle after that grant with rdata=0xA5.
- Conflict (MEMORY_ARBITER_RR_EN defined): req0 and req1 are both held high for 4 cycles. Grants alternate 0,1,0,1, and each rvalid follows its grant by one cycle.
- Conflict (MEMORY_ARBITER_RR_EN undefined): the same stimulus gives gnt0 on all 4 cycles and gnt1 never.
- Clear sweep:
  - ADDRESS_WIDTH=4, CLEAR_VALUE=0x3C, pulse clr_start while req1 is high.
  - clr_busy stays high for 16 cycles with gnt1=0 throughout.
  - gnt1 fires the cycle clr_busy falls; reading any address then returns 0x3C.
- Reset mid-clear: assert rst_n=0 at sweep cycle 5. clr_busy drops immediately and addresses 0..4 read CLEAR_VALUE.
